instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high.
REQ-003 SHALL have port start, input, 1, one-cycle pulse beginning a program load.
REQ-004 SHALL have port base_addr, input, 12, first imem word address, sampled on start.
REQ-005 SHALL have port in_valid, input, 1, an instruction field set is presented.
REQ-006 SHALL have port in_ready, output, 1, the encoder accepts a field set this cycle.
REQ-007 SHALL have port in_last, input, 1, the presented field set is the final instruction.
REQ-008 SHALL have ports opcode, rd, rs, rt, shamt, aluop, inputs, 5 bits each, instruction fields.
REQ-009 SHALL have ports imm (17 bits) and target (27 bits), inputs, immediate and jump target.
REQ-010 SHALL have port mem_ready, input, 1, imem can take a write this cycle.
REQ-011 SHALL have ports imem_we (1), imem_addr (12) and imem_data (32), outputs, imem write port.
REQ-012 SHALL have port busy, output, 1, high in LOAD and FLUSH.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when the load completes.
REQ-014 SHALL have port err, output, 1, sticky flag for an invalid opcode.

Function
REQ-015 Encoding SHALL be: opcode at [31:27] for every format.
REQ-016 R format (00000) SHALL be rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2], [1:0]=0.
REQ-017 I format (00010 bne, 00101 addi, 00110 blt, 00111 sw, 01000 lw, 01001 isw, 01010 ilw) SHALL be rd[26:22], rs[21:17], imm[16:0].
REQ-018 JI format (00001 j, 00011 jal, 10101 setx, 10110 bex) SHALL be target[26:0].
REQ-019 JII format (00100 jr, 01011 ri, 01100 rtick, 01101 rsec) SHALL be rd[26:22], [21:0]=0.
REQ-020 Fields unused by a format SHALL be ignored.
REQ-021 Any other opcode SHALL be accepted but not written, and SHALL set err.
REQ-022 The FSM SHALL have states IDLE, LOAD, FLUSH and DONE.
REQ-023 IDLE plus start SHALL load the write address from base_addr, clear err and go to LOAD.
REQ-024 LOAD SHALL go to FLUSH on an accepted beat with in_last=1.
REQ-025 FLUSH SHALL go to DONE when the FIFO is empty, with no write in flight.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 The block SHALL buffer encoded words in a 4-entry FIFO; a beat is accepted when in_valid and in_ready are both high.
REQ-029 in_ready SHALL be 1 only in LOAD with FIFO occupancy below 4.
REQ-030 A beat accepted at full-minus-one with a simultaneous pop SHALL be legal, and occupancy SHALL remain correct.
REQ-031 imem_we SHALL equal (FIFO not empty and mem_ready); imem_data SHALL be the FIFO head and imem_addr the current write address.
REQ-032 Latency SHALL be: a word accepted into an empty FIFO with mem_ready=1 appears with imem_we=1 on the next cycle.
REQ-033 The write address SHALL increment by 1 per write, wrapping from 4095 to 0.
REQ-034 Word order SHALL equal acceptance order; mem_ready low SHALL hold the head and address stable.

Reset
REQ-035 reset SHALL force IDLE, FIFO empty, write address 0, and in_ready, imem_we, busy, done and err all 0.
REQ-036 reset SHALL take priority over all other inputs, including mid-load; buffered words SHALL be discarded and no write issued that cycle.

Verification
REQ-037 addi (rd=3, rs=1, imm=5) at base 0x010 -> imem_data=0x28C20005, imem_addr=0x010, one cycle after accept.
REQ-038 R (rd=1, rs=2, rt=3, aluop=0), then j target=0x100 with in_last -> 0x00443000 @base, 0x08000100 @base+1; done pulses once, then busy=0.
REQ-039 mem_ready held low, 5 beats offered -> in_ready drops after 4; release -> 4 writes, then the 5th, in order, no loss.
REQ-040 jr rd=31 at base 0xFFF, then a second instruction -> 0x27C00000 @0xFFF, next write @0x000.
REQ-041 opcode 11111 mid-stream -> no write for it, err=1 until next start, subsequent addresses contiguous.
REQ-042 reset asserted in LOAD with 3 words buffered -> next cycle IDLE, imem_we=0, err=0; a new load starts cleanly.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: encodes instruction field sets into 32-bit words and streams them into imem through a 4-deep FIFO
module instr_encoder (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [11:0] base_addr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_last,
   input  logic [4:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  shamt,
   input  logic [4:0]  aluop,
   input  logic [16:0] imm,
   input  logic [26:0] target,
   input  logic        mem_ready,
   output logic        imem_we,
   output logic [11:0] imem_addr,
   output logic [31:0] imem_data,
   output logic        busy,
   output logic        done,
   output logic        err
);
   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
   state_t      state_q, state_d;
   logic [31:0] fifo_q [4];
   logic [1:0]  wr_ptr_q, rd_ptr_q;
   logic [2:0]  cnt_q;
   logic [11:0] addr_q;
   logic        err_q;
   logic        is_r, is_i, is_ji, is_jii, op_ok, accept, push, pop;
   logic [31:0] enc;
   assign is_r   = opcode == 5'd0;
   assign is_i   = opcode inside {5'd2, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10};
   assign is_ji  = opcode inside {5'd1, 5'd3, 5'd21, 5'd22};
   assign is_jii = opcode inside {5'd4, 5'd11, 5'd12, 5'd13};
   assign op_ok  = is_r | is_i | is_ji | is_jii;
   assign enc = {opcode, is_r   ? {rd, rs, rt, shamt, aluop, 2'b00} :
                         is_i   ? {rd, rs, imm} :
                         is_ji  ? target :
                         is_jii ? {rd, 22'd0} : 27'd0};
   // reset gates the handshake outputs so nothing is accepted or written during the reset cycle
   assign in_ready  = !reset && state_q == LOAD && cnt_q != 3'd4;
   assign accept    = in_valid && in_ready;
   assign push      = accept && op_ok;
   assign imem_we   = !reset && cnt_q != 3'd0 && mem_ready;
   assign pop       = imem_we;
   assign imem_data = fifo_q[rd_ptr_q];
   assign imem_addr = addr_q;
   assign err       = !reset && err_q;
   // state register plus FIFO pointers, write address and sticky error
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         cnt_q    <= 3'd0;
         addr_q   <= 12'd0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
         if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
         cnt_q <= cnt_q + {2'b00, push} - {2'b00, pop};
         if (state_q == IDLE && start) begin
            addr_q <= base_addr;
            err_q  <= 1'b0;
         end else begin
            if (pop) addr_q <= addr_q + 12'd1;
            if (accept && !op_ok) err_q <= 1'b1;
         end
      end
   end
   // FIFO storage needs no reset; occupancy alone decides what is valid
   always_ff @(posedge clock) begin
      if (push) fifo_q[wr_ptr_q] <= enc;
   end
   // next-state: load on start, flush after the last beat, done once drained
   always_comb begin
      state_d = (state_q == IDLE && start)                ? LOAD  :
                (state_q == LOAD && accept && in_last)    ? FLUSH :
                (state_q == FLUSH && cnt_q == 3'd0)       ? DONE  :
                (state_q == DONE)                         ? IDLE  : state_q;
   end
   // status outputs decoded from the current state
   always_comb begin
      busy = !reset && (state_q == LOAD || state_q == FLUSH);
      done = !reset && state_q == DONE;
   end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scoreboard bench for instr_encoder
module tb_instr_encoder;
   logic        clock, reset, start, in_valid, in_ready, in_last, mem_ready;
   logic        imem_we, busy, done, err;
   logic [11:0] base_addr, imem_addr;
   logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
   logic [16:0] imm;
   logic [26:0] target;
   logic [31:0] imem_data;
   typedef struct {logic [11:0] addr; logic [31:0] data;} wr_t;
   wr_t         sb[$];
   logic [11:0] exp_addr;
   int          checks = 0, failures = 0, wr_cnt = 0, wr_base;
   instr_encoder dut (
      .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .shamt(shamt), .aluop(aluop),
      .imm(imm), .target(target), .mem_ready(mem_ready), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_data(imem_data), .busy(busy), .done(done), .err(err)
   );
   initial clock = 1'b0;
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic logic [31:0] ref_enc(input logic [4:0] op, input logic [4:0] d, input logic [4:0] s,
                                           input logic [4:0] t, input logic [4:0] sh, input logic [4:0] alu,
                                           input logic [16:0] im, input logic [26:0] tg);
      case (op)
         5'd0: return {op, d, s, t, sh, alu, 2'b00};
         5'd2, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: return {op, d, s, im};
         5'd1, 5'd3, 5'd21, 5'd22: return {op, tg};
         5'd4, 5'd11, 5'd12, 5'd13: return {op, d, 22'd0};
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction
   // scoreboard: compare writes against queue head, then enqueue newly accepted valid beats
   always @(negedge clock) begin
      wr_t e;
      logic [31:0] w;
      if (imem_we) begin
         wr_cnt++;
         if (sb.size() == 0) chk("unexpected_write", {31'd0, imem_we}, 32'd0);
         else begin
            e = sb.pop_front();
            chk("wr_addr", {20'd0, imem_addr}, {20'd0, e.addr});
            chk("wr_data", imem_data, e.data);
         end
      end
      if (in_valid && in_ready) begin
         w = ref_enc(opcode, rd, rs, rt, shamt, aluop, imm, target);
         if (w != 32'hFFFF_FFFF) begin
            sb.push_back('{exp_addr, w});
            exp_addr = exp_addr + 12'd1;
         end
      end
   end
   task automatic do_start(input logic [11:0] b);
      start = 1'b1; base_addr = b; exp_addr = b;
      @(posedge clock); #1;
      start = 1'b0;
   endtask
   task automatic drive(input logic [4:0] op, input logic [4:0] d, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] alu, input logic [16:0] im, input logic [26:0] tg, input logic last);
      opcode = op; rd = d; rs = s; rt = t; shamt = 5'd0; aluop = alu; imm = im; target = tg;
      in_last = last; in_valid = 1'b1;
   endtask
   task automatic accept_wait();
      int n = 0;
      @(negedge clock);
      while (!in_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("accept_in_time", {31'd0, in_ready}, 32'd1);
      @(posedge clock); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask
   task automatic send(input logic [4:0] op, input logic [4:0] d, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] alu, input logic [16:0] im, input logic [26:0] tg, input logic last);
      drive(op, d, s, t, alu, im, tg, last);
      accept_wait();
   endtask
   task automatic wait_done();
      int n = 0;
      @(negedge clock);
      while (!done && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
      @(negedge clock);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      @(posedge clock); #1;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   initial begin
      reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b1;
      opcode = '0; rd = '0; rs = '0; rt = '0; shamt = '0; aluop = '0; imm = '0; target = '0; exp_addr = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_imem_we", {31'd0, imem_we}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("idle_addr", {20'd0, imem_addr}, 32'd0);
      chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clock); #1;
      // addi with one-cycle write latency
      do_start(12'h010);
      send(5'd5, 5'd3, 5'd1, 5'd0, 5'd0, 17'd5, 27'd0, 1'b1);
      @(negedge clock);
      chk("addi_we", {31'd0, imem_we}, 32'd1);
      chk("addi_data", imem_data, 32'h28C2_0005);
      chk("addi_addr", {20'd0, imem_addr}, 32'h010);
      wait_done();
      // R then j, contiguous addresses
      do_start(12'h020);
      send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 17'd0, 27'd0, 1'b0);
      send(5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'h100, 1'b1);
      wait_done();
      chk("r_j_words", ref_enc(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 17'd0, 27'd0), 32'h0044_3000);
      // backpressure: FIFO fills, fifth beat waits, then everything drains in order
      mem_ready = 1'b0;
      wr_base = wr_cnt;
      do_start(12'h100);
      for (int i = 0; i < 4; i++) send(5'd8, 5'(i), 5'd2, 5'd0, 5'd0, 17'(i * 3 + 1), 27'd0, 1'b0);
      drive(5'd6, 5'd9, 5'd4, 5'd0, 5'd0, 17'h1ABCD, 27'd0, 1'b1);
      @(negedge clock);
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      chk("full_no_write", {31'd0, imem_we}, 32'd0);
      @(negedge clock);
      chk("hold_addr", {20'd0, imem_addr}, 32'h100);
      chk("hold_data", imem_data, ref_enc(5'd8, 5'd0, 5'd2, 5'd0, 5'd0, 5'd0, 17'd1, 27'd0));
      @(posedge clock); #1;
      mem_ready = 1'b1;
      accept_wait();
      wait_done();
      chk("bp_write_count", 32'(wr_cnt - wr_base), 32'd5);
      // address wrap at 4095
      do_start(12'hFFF);
      send(5'd4, 5'd31, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 1'b0);
      @(negedge clock);
      chk("jr_data", imem_data, 32'h27C0_0000);
      chk("jr_addr", {20'd0, imem_addr}, 32'hFFF);
      @(posedge clock); #1;
      send(5'd5, 5'd2, 5'd2, 5'd0, 5'd0, 17'd7, 27'd0, 1'b1);
      @(negedge clock);
      chk("wrap_addr", {20'd0, imem_addr}, 32'h000);
      @(posedge clock); #1;
      wait_done();
      // invalid opcode mid-stream
      wr_base = wr_cnt;
      do_start(12'h200);
      send(5'd5, 5'd1, 5'd0, 5'd0, 5'd0, 17'd9, 27'd0, 1'b0);
      send(5'd31, 5'd7, 5'd7, 5'd7, 5'd7, 17'd7, 27'd7, 1'b0);
      @(negedge clock);
      chk("bad_op_err", {31'd0, err}, 32'd1);
      @(posedge clock); #1;
      send(5'd8, 5'd4, 5'd5, 5'd0, 5'd0, 17'h10, 27'd0, 1'b1);
      wait_done();
      chk("bad_op_writes", 32'(wr_cnt - wr_base), 32'd2);
      chk("err_sticky", {31'd0, err}, 32'd1);
      // reset mid-load with three words buffered
      mem_ready = 1'b0;
      do_start(12'h300);
      @(negedge clock);
      chk("start_clears_err", {31'd0, err}, 32'd0);
      @(posedge clock); #1;
      for (int i = 0; i < 3; i++) send(5'd2, 5'd1, 5'(i), 5'd0, 5'd0, 17'(i), 27'd0, 1'b0);
      send(5'd30, 5'd0, 5'd0, 5'd0, 5'd0, 17'd0, 27'd0, 1'b0);
      @(negedge clock);
      chk("pre_rst_err", {31'd0, err}, 32'd1);
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      @(posedge clock); #1;
      reset = 1'b1; mem_ready = 1'b1;
      sb.delete();
      @(negedge clock);
      chk("rst_cycle_no_write", {31'd0, imem_we}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_we", {31'd0, imem_we}, 32'd0);
      chk("post_rst_err", {31'd0, err}, 32'd0);
      chk("post_rst_addr", {20'd0, imem_addr}, 32'd0);
      @(posedge clock); #1;
      do_start(12'h040);
      send(5'd5, 5'd3, 5'd1, 5'd0, 5'd0, 17'd5, 27'd0, 1'b1);
      @(negedge clock);
      chk("reload_data", imem_data, 32'h28C2_0005);
      chk("reload_addr", {20'd0, imem_addr}, 32'h040);
      wait_done();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
